// File: rtl/cpld_ramexp_ctrl_if.sv
// Z80 expansion-connector signals seen by the RAM expansion CPLD, plus the RAM-side controls.
// The master is the host/connector side; the slave is the controller.
interface cpld_ramexp_ctrl_if #(
   parameter int BANK_BITS = 3
);
   logic [7:0]           adr_hi;
   logic [7:0]           data;
   logic                 iorq_b;
   logic                 mreq_b;
   logic                 rfsh_b;
   logic                 rd_b;
   logic                 wr_b;
   logic                 ready;
   logic                 mode464;
   logic                 ramcs_b;
   logic                 ramoe_b;
   logic                 ramwe_b;
   logic [BANK_BITS+1:0] ramadrhi;
   logic                 ramdis;
   logic                 adr15_oe;
   logic                 rdb_oe;
   logic [1:0]           dbg_state;

   modport master (
      output adr_hi, data, iorq_b, mreq_b, rfsh_b, rd_b, wr_b, ready, mode464,
      input  ramcs_b, ramoe_b, ramwe_b, ramadrhi, ramdis, adr15_oe, rdb_oe, dbg_state
   );

   modport slave (
      input  adr_hi, data, iorq_b, mreq_b, rfsh_b, rd_b, wr_b, ready, mode464,
      output ramcs_b, ramoe_b, ramwe_b, ramadrhi, ramdis, adr15_oe, rdb_oe, dbg_state
   );
endinterface

// File: rtl/cpld_ramexp_ctrl.sv
// Z80 RAM expansion controller: decodes bank-select OUTs, maps 16K blocks of each memory
// cycle onto banked expansion RAM, and drives the A15/RD* overdrive for 464-type hosts.
module cpld_ramexp_ctrl #(
   parameter int BANK_BITS = 3,
   parameter int NUM_BANKS = 8,
   parameter int OVERDRIVE = 1
) (
   input logic               clk,
   input logic               reset,
   cpld_ramexp_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      WAIT   = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t               state;
   logic                 iorq_q, mreq_q, mreq_qq, wr_q, rd_q;
   logic                 io_done_q;
   logic [BANK_BITS-1:0] bank_q, map_bank_q, new_bank;
   logic [2:0]           mode_q;
   logic                 a15_q, a14_q, wr_cyc_q, map_q, pend_q;
   logic [1:0]           block_q;
   logic                 ramcs_b_q, ramdis_q, adr15_oe_q, rdb_oe_q;
   logic [BANK_BITS+1:0] ramadrhi_q;

   logic                 bank_wr, mreq_fall, start, bank_ok, hit, in_cyc, mapped, cs_on, od_en;
   logic [1:0]           blk;

   // Low three bank bits come from the data bus; wider banks extend upward with inverted A10..A8.
   if (BANK_BITS > 3) begin : g_wide_bank
      assign new_bank = {~bus.adr_hi[BANK_BITS-4:0], bus.data[5:3]};
   end else begin : g_narrow_bank
      assign new_bank = bus.data[5:3];
   end

   assign bank_ok   = {{(32-BANK_BITS){1'b0}}, bank_q} < 32'(NUM_BANKS);
   assign bank_wr   = !iorq_q && !wr_q && !bus.adr_hi[7] && (bus.data[7:6] == 2'b11) && !io_done_q;
   assign mreq_fall = mreq_qq && !mreq_q;
   assign start     = (mreq_fall || (pend_q && !mreq_q)) && bus.rfsh_b && iorq_q;
   assign in_cyc    = (state != IDLE);
   assign mapped    = map_q && in_cyc;
   assign cs_on     = mapped && (!mreq_q || state == HOLD);
   assign od_en     = (OVERDRIVE != 0) && bus.mode464;

   always_comb begin
      hit = 1'b0;
      blk = 2'b00;
      if (mode_q[2]) begin
         hit = (bus.adr_hi[7:6] == 2'b01);
         blk = mode_q[1:0];
      end else begin
         case (mode_q[1:0])
            2'b01, 2'b11: begin
               hit = (bus.adr_hi[7:6] == 2'b11);
               blk = 2'b11;
            end
            2'b10: begin
               hit = 1'b1;
               blk = bus.adr_hi[7:6];
            end
            default: hit = 1'b0;
         endcase
      end
      if (!bank_ok) hit = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         iorq_q     <= 1'b1;
         mreq_q     <= 1'b1;
         mreq_qq    <= 1'b1;
         wr_q       <= 1'b1;
         rd_q       <= 1'b1;
         io_done_q  <= 1'b0;
         bank_q     <= '0;
         mode_q     <= 3'b000;
         map_bank_q <= '0;
         a15_q      <= 1'b0;
         a14_q      <= 1'b0;
         wr_cyc_q   <= 1'b0;
         map_q      <= 1'b0;
         pend_q     <= 1'b0;
         block_q    <= 2'b00;
         ramcs_b_q  <= 1'b1;
         ramdis_q   <= 1'b0;
         adr15_oe_q <= 1'b0;
         rdb_oe_q   <= 1'b0;
         ramadrhi_q <= '0;
      end else begin
         iorq_q    <= bus.iorq_b;
         mreq_q    <= bus.mreq_b;
         mreq_qq   <= mreq_q;
         wr_q      <= bus.wr_b;
         rd_q      <= bus.rd_b;
         io_done_q <= iorq_q ? 1'b0 : (io_done_q || bank_wr);
         if (bank_wr) begin
            bank_q <= new_bank;
            mode_q <= bus.data[2:0];
         end

         ramcs_b_q  <= !cs_on;
         ramdis_q   <= cs_on;
         ramadrhi_q <= mapped ? {map_bank_q, block_q} : '0;
         adr15_oe_q <= od_en && (mode_q == 3'b011) && !a15_q && a14_q && in_cyc;
         rdb_oe_q   <= od_en && mapped && (!mreq_q || (wr_cyc_q && state == HOLD));

         case (state)
            IDLE: begin
               pend_q <= 1'b0;
               if (start) begin
                  a15_q      <= bus.adr_hi[7];
                  a14_q      <= bus.adr_hi[6];
                  wr_cyc_q   <= rd_q;
                  map_q      <= hit;
                  block_q    <= blk;
                  map_bank_q <= bank_q;
                  state      <= bus.ready ? ACTIVE : WAIT;
               end
            end
            WAIT:    if (bus.ready) state <= ACTIVE;
            ACTIVE:  if (mreq_q) state <= HOLD;
            // A new MREQ edge seen here is remembered and re-qualified in IDLE.
            HOLD: begin
               pend_q <= mreq_fall;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ramcs_b   = ramcs_b_q;
   assign bus.ramdis    = ramdis_q;
   assign bus.ramadrhi  = ramadrhi_q;
   assign bus.adr15_oe  = adr15_oe_q;
   assign bus.rdb_oe    = rdb_oe_q;
   assign bus.ramoe_b   = bus.rd_b;
   assign bus.ramwe_b   = bus.wr_b;
   assign bus.dbg_state = state;
endmodule

// File: tb/tb_cpld_ramexp_ctrl.sv
// Directed bench for cpld_ramexp_ctrl: three parameterisations share one Z80 bus.
module tb_cpld_ramexp_ctrl;
   localparam logic [1:0] ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_WAIT = 2'd2, ST_HOLD = 2'd3;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] adr_hi, data;
   logic       iorq_b, mreq_b, rfsh_b, rd_b, wr_b, ready, mode464;
   int         n_cmp = 0;
   int         n_bad = 0;

   always #5 clk = ~clk;

   cpld_ramexp_ctrl_if #(.BANK_BITS(3)) if_a ();
   cpld_ramexp_ctrl_if #(.BANK_BITS(6)) if_b ();
   cpld_ramexp_ctrl_if #(.BANK_BITS(3)) if_c ();

   assign if_a.adr_hi = adr_hi;  assign if_b.adr_hi = adr_hi;  assign if_c.adr_hi = adr_hi;
   assign if_a.data = data;      assign if_b.data = data;      assign if_c.data = data;
   assign if_a.iorq_b = iorq_b;  assign if_b.iorq_b = iorq_b;  assign if_c.iorq_b = iorq_b;
   assign if_a.mreq_b = mreq_b;  assign if_b.mreq_b = mreq_b;  assign if_c.mreq_b = mreq_b;
   assign if_a.rfsh_b = rfsh_b;  assign if_b.rfsh_b = rfsh_b;  assign if_c.rfsh_b = rfsh_b;
   assign if_a.rd_b = rd_b;      assign if_b.rd_b = rd_b;      assign if_c.rd_b = rd_b;
   assign if_a.wr_b = wr_b;      assign if_b.wr_b = wr_b;      assign if_c.wr_b = wr_b;
   assign if_a.ready = ready;    assign if_b.ready = ready;    assign if_c.ready = ready;
   assign if_a.mode464 = mode464; assign if_b.mode464 = mode464; assign if_c.mode464 = mode464;

   cpld_ramexp_ctrl #(.BANK_BITS(3), .NUM_BANKS(8),  .OVERDRIVE(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
   cpld_ramexp_ctrl #(.BANK_BITS(6), .NUM_BANKS(64), .OVERDRIVE(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
   cpld_ramexp_ctrl #(.BANK_BITS(3), .NUM_BANKS(4),  .OVERDRIVE(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic io_out(input logic [7:0] a, input logic [7:0] d);
      adr_hi = a; data = d; iorq_b = 1'b0; wr_b = 1'b0;
      repeat (3) tick();
      iorq_b = 1'b1; wr_b = 1'b1;
      repeat (2) tick();
   endtask

   // Leaves the bus mid-cycle with outputs reflecting ACTIVE.
   task automatic mem_begin(input logic [7:0] a, input bit is_rd);
      adr_hi = a; mreq_b = 1'b0; rd_b = !is_rd; wr_b = is_rd;
      repeat (4) tick();
   endtask

   task automatic mem_end();
      mreq_b = 1'b1; rd_b = 1'b1; wr_b = 1'b1;
      repeat (5) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; adr_hi = 8'h00; data = 8'h00; iorq_b = 1'b1; mreq_b = 1'b1; rfsh_b = 1'b1;
      rd_b = 1'b1; wr_b = 1'b1; ready = 1'b1; mode464 = 1'b0;
      repeat (3) tick();
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL rst_ramcs_b: got %b exp 1", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramdis !== 1'b0) begin n_bad++; $display("FAIL rst_ramdis: got %b exp 0", if_a.ramdis); end
      n_cmp++; if (if_a.adr15_oe !== 1'b0) begin n_bad++; $display("FAIL rst_adr15_oe: got %b exp 0", if_a.adr15_oe); end
      n_cmp++; if (if_a.rdb_oe !== 1'b0) begin n_bad++; $display("FAIL rst_rdb_oe: got %b exp 0", if_a.rdb_oe); end
      n_cmp++; if (if_a.ramadrhi !== 5'b00000) begin n_bad++; $display("FAIL rst_ramadrhi: got %b exp 00000", if_a.ramadrhi); end
      n_cmp++; if (if_a.dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d exp %0d", if_a.dbg_state, ST_IDLE); end
      reset = 1'b0;
      repeat (2) tick();
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL rst_mode0_cs: got %b exp 1", if_a.ramcs_b); end
      mem_end();
   endtask

   task automatic test_basic_map();
      io_out(8'h7F, 8'hC2);  // bank 0, mode 010
      mem_begin(8'h80, 1'b1);
      n_cmp++; if (if_a.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL map_cs: got %b exp 0", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramdis !== 1'b1) begin n_bad++; $display("FAIL map_ramdis: got %b exp 1", if_a.ramdis); end
      n_cmp++; if (if_a.ramadrhi !== 5'b00010) begin n_bad++; $display("FAIL map_adr_8000: got %b exp 00010", if_a.ramadrhi); end
      n_cmp++; if (if_c.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL map_c_cs: got %b exp 0", if_c.ramcs_b); end
      mem_end();
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL map_idle_cs: got %b exp 1", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramadrhi !== 5'b00000) begin n_bad++; $display("FAIL map_idle_adr: got %b exp 00000", if_a.ramadrhi); end
      mem_begin(8'h00, 1'b0);
      n_cmp++; if (if_a.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL map_blk0_cs: got %b exp 0", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramwe_b !== 1'b0) begin n_bad++; $display("FAIL map_ramwe_b: got %b exp 0", if_a.ramwe_b); end
      mem_end();
   endtask

   task automatic test_once_per_iorq();
      adr_hi = 8'h7F; data = 8'hC2; iorq_b = 1'b0; wr_b = 1'b0;
      repeat (2) tick();
      data = 8'hFF;  // same IORQ: must be ignored
      repeat (3) tick();
      iorq_b = 1'b1; wr_b = 1'b1;
      repeat (2) tick();
      io_out(8'hFF, 8'hFF);  // A15 high: not a bank write
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL once_cs: got %b exp 0", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramadrhi !== 5'b00011) begin n_bad++; $display("FAIL once_adr: got %b exp 00011", if_a.ramadrhi); end
      mem_end();
   endtask

   task automatic test_wide_bank();
      // A10..A8 = 000 inverts to 111, data[5:3] = 111: wide bank 63, mode 111.
      io_out(8'h78, 8'hFF);
      mem_begin(8'h40, 1'b1);
      n_cmp++; if (if_b.ramadrhi !== 8'hFF) begin n_bad++; $display("FAIL wide_adr_b: got %b exp 11111111", if_b.ramadrhi); end
      n_cmp++; if (if_b.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL wide_cs_b: got %b exp 0", if_b.ramcs_b); end
      n_cmp++; if (if_a.ramadrhi !== 5'b11111) begin n_bad++; $display("FAIL wide_adr_a: got %b exp 11111", if_a.ramadrhi); end
      n_cmp++; if (if_c.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL wide_cs_c: got %b exp 1", if_c.ramcs_b); end
      n_cmp++; if (if_c.ramadrhi !== 5'b00000) begin n_bad++; $display("FAIL wide_adr_c: got %b exp 00000", if_c.ramadrhi); end
      mem_end();
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL wide_c000_cs: got %b exp 1", if_a.ramcs_b); end
      mem_end();
   endtask

   task automatic test_num_banks();
      io_out(8'h7F, 8'hE9);  // bank 5, mode 001
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_c.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL nb_cs_c: got %b exp 1", if_c.ramcs_b); end
      n_cmp++; if (if_c.ramdis !== 1'b0) begin n_bad++; $display("FAIL nb_ramdis_c: got %b exp 0", if_c.ramdis); end
      n_cmp++; if (if_a.ramadrhi !== 5'b10111) begin n_bad++; $display("FAIL nb_adr_a: got %b exp 10111", if_a.ramadrhi); end
      n_cmp++; if (if_b.ramadrhi !== 8'h17) begin n_bad++; $display("FAIL nb_adr_b: got %b exp 00010111", if_b.ramadrhi); end
      mem_end();
   endtask

   task automatic test_overdrive();
      mode464 = 1'b1;
      io_out(8'h7F, 8'hC3);  // bank 0, mode 011
      adr_hi = 8'h40; mreq_b = 1'b0; wr_b = 1'b0; ready = 1'b0;
      repeat (3) tick();
      n_cmp++; if (if_a.dbg_state !== ST_WAIT) begin n_bad++; $display("FAIL od_state_wait: got %0d exp %0d", if_a.dbg_state, ST_WAIT); end
      n_cmp++; if (if_a.adr15_oe !== 1'b1) begin n_bad++; $display("FAIL od_a15_wait: got %b exp 1", if_a.adr15_oe); end
      ready = 1'b1;
      repeat (2) tick();
      n_cmp++; if (if_a.dbg_state !== ST_ACTIVE) begin n_bad++; $display("FAIL od_state_active: got %0d exp %0d", if_a.dbg_state, ST_ACTIVE); end
      n_cmp++; if (if_a.adr15_oe !== 1'b1) begin n_bad++; $display("FAIL od_a15_active: got %b exp 1", if_a.adr15_oe); end
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL od_cs_unmapped: got %b exp 1", if_a.ramcs_b); end
      mreq_b = 1'b1; wr_b = 1'b1;
      repeat (2) tick();
      n_cmp++; if (if_a.dbg_state !== ST_HOLD) begin n_bad++; $display("FAIL od_state_hold: got %0d exp %0d", if_a.dbg_state, ST_HOLD); end
      tick();
      n_cmp++; if (if_a.adr15_oe !== 1'b1) begin n_bad++; $display("FAIL od_a15_hold: got %b exp 1", if_a.adr15_oe); end
      tick();
      n_cmp++; if (if_a.adr15_oe !== 1'b0) begin n_bad++; $display("FAIL od_a15_idle: got %b exp 0", if_a.adr15_oe); end
      tick();
   endtask

   task automatic test_rdb_oe();
      io_out(8'h7F, 8'hC2);  // bank 0, mode 010; mode464 still 1
      mem_begin(8'hC0, 1'b0);
      n_cmp++; if (if_a.rdb_oe !== 1'b1) begin n_bad++; $display("FAIL rdb_wr_active: got %b exp 1", if_a.rdb_oe); end
      mreq_b = 1'b1; wr_b = 1'b1;
      repeat (3) tick();
      n_cmp++; if (if_a.rdb_oe !== 1'b1) begin n_bad++; $display("FAIL rdb_wr_hold: got %b exp 1", if_a.rdb_oe); end
      n_cmp++; if (if_a.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL rdb_cs_hold: got %b exp 0", if_a.ramcs_b); end
      tick();
      n_cmp++; if (if_a.rdb_oe !== 1'b0) begin n_bad++; $display("FAIL rdb_wr_idle: got %b exp 0", if_a.rdb_oe); end
      tick();
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.rdb_oe !== 1'b1) begin n_bad++; $display("FAIL rdb_rd_active: got %b exp 1", if_a.rdb_oe); end
      mreq_b = 1'b1; rd_b = 1'b1;
      repeat (3) tick();
      n_cmp++; if (if_a.rdb_oe !== 1'b0) begin n_bad++; $display("FAIL rdb_rd_hold: got %b exp 0", if_a.rdb_oe); end
      repeat (2) tick();
      mode464 = 1'b0;
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.rdb_oe !== 1'b0) begin n_bad++; $display("FAIL rdb_no464: got %b exp 0", if_a.rdb_oe); end
      n_cmp++; if (if_a.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL rdb_no464_cs: got %b exp 0", if_a.ramcs_b); end
      mem_end();
   endtask

   task automatic test_bank_midcycle();
      mem_begin(8'hC0, 1'b1);
      adr_hi = 8'h7F; data = 8'hD2; iorq_b = 1'b0; wr_b = 1'b0;  // bank 2, mode 010
      repeat (3) tick();
      n_cmp++; if (if_a.ramadrhi !== 5'b00011) begin n_bad++; $display("FAIL mid_old_adr: got %b exp 00011", if_a.ramadrhi); end
      adr_hi = 8'hC0; iorq_b = 1'b1; wr_b = 1'b1;
      mem_end();
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.ramadrhi !== 5'b01011) begin n_bad++; $display("FAIL mid_new_adr: got %b exp 01011", if_a.ramadrhi); end
      mem_end();
   endtask

   task automatic test_refresh();
      rfsh_b = 1'b0;
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL rfsh_cs: got %b exp 1", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramdis !== 1'b0) begin n_bad++; $display("FAIL rfsh_ramdis: got %b exp 0", if_a.ramdis); end
      n_cmp++; if (if_a.dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL rfsh_state: got %0d exp %0d", if_a.dbg_state, ST_IDLE); end
      mem_end();
      rfsh_b = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_back_to_back();
      mem_begin(8'hC0, 1'b1);
      mreq_b = 1'b1; rd_b = 1'b1;
      tick();
      adr_hi = 8'h00; mreq_b = 1'b0; rd_b = 1'b0;  // falls while the FSM is in HOLD
      repeat (4) tick();
      n_cmp++; if (if_a.dbg_state !== ST_ACTIVE) begin n_bad++; $display("FAIL b2b_state: got %0d exp %0d", if_a.dbg_state, ST_ACTIVE); end
      n_cmp++; if (if_a.ramadrhi !== 5'b01000) begin n_bad++; $display("FAIL b2b_adr: got %b exp 01000", if_a.ramadrhi); end
      n_cmp++; if (if_a.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL b2b_cs: got %b exp 0", if_a.ramcs_b); end
      mem_end();
      mem_begin(8'hC0, 1'b1);
      mreq_b = 1'b1; rd_b = 1'b1;
      tick();
      mreq_b = 1'b0;
      tick();
      mreq_b = 1'b1;  // gone again before IDLE
      repeat (4) tick();
      n_cmp++; if (if_a.dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL b2b_drop_state: got %0d exp %0d", if_a.dbg_state, ST_IDLE); end
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL b2b_drop_cs: got %b exp 1", if_a.ramcs_b); end
      repeat (2) tick();
   endtask

   task automatic test_reset_midcycle();
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.ramcs_b !== 1'b0) begin n_bad++; $display("FAIL rmid_pre_cs: got %b exp 0", if_a.ramcs_b); end
      reset = 1'b1;
      tick();
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL rmid_cs: got %b exp 1", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramdis !== 1'b0) begin n_bad++; $display("FAIL rmid_ramdis: got %b exp 0", if_a.ramdis); end
      n_cmp++; if (if_a.dbg_state !== ST_IDLE) begin n_bad++; $display("FAIL rmid_state: got %0d exp %0d", if_a.dbg_state, ST_IDLE); end
      reset = 1'b0;
      mem_end();
      mem_begin(8'hC0, 1'b1);
      n_cmp++; if (if_a.ramcs_b !== 1'b1) begin n_bad++; $display("FAIL rmid_after_cs: got %b exp 1", if_a.ramcs_b); end
      n_cmp++; if (if_a.ramadrhi !== 5'b00000) begin n_bad++; $display("FAIL rmid_after_adr: got %b exp 00000", if_a.ramadrhi); end
      mem_end();
   endtask

   initial begin
      test_reset();
      test_basic_map();
      test_once_per_iorq();
      test_wide_bank();
      test_num_banks();
      test_overdrive();
      test_rdb_oe();
      test_bank_midcycle();
      test_refresh();
      test_back_to_back();
      test_reset_midcycle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
